// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants and helpers for the multiplexed BCD display scanner.
package bcd_disp_pkg;

  localparam int BCD_W   = 4;
  localparam int BCD_MAX = 9;

  // Widest digit vector the nibble helper accepts (64 digits).
  localparam int NIB_SRC_W = 256;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [BCD_W-1:0] get_nibble(input logic [NIB_SRC_W-1:0] v,
                                                  input int idx);
    return BCD_W'(v >> (idx * BCD_W));
  endfunction

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Load/display bundle between a digit source and the scanner.
interface bcd_display_scanner_if
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic                        load;
  logic [BCD_W*NUM_DIGITS-1:0] digits_in;
  logic                        A;
  logic                        B;
  logic                        C;
  logic                        D;
  logic [NUM_DIGITS-1:0]       digit_en;
  logic                        blank;
  logic                        pending;
  logic                        invalid;

  modport master (
    output load, digits_in,
    input  A, B, C, D, digit_en, blank, pending, invalid
  );

  modport slave (
    input  load, digits_in,
    output A, B, C, D, digit_en, blank, pending, invalid
  );

endinterface

// File: rtl/bcd_display_scanner_prescaler.sv
// Free-running 0..DIV-1 counter; tick is high during the last count of each period.
module disp_prescaler
  import bcd_disp_pkg::*;
#(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = idx_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed 7448 driver: double-buffered BCD digits scanned one at a time.
// Build option LEADING_ZERO_BLANK_EN blanks zero digits above the highest non-zero one.
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_display_scanner_if.slave  bus
);

  localparam int                W        = BCD_W * NUM_DIGITS;
  localparam int                IW       = idx_w(NUM_DIGITS);
  localparam logic [IW-1:0]     LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [BCD_W-1:0]  MAX_NIB  = BCD_W'(BCD_MAX);

  if (W > NIB_SRC_W) begin : g_width_check
    $error("bcd_display_scanner: NUM_DIGITS exceeds nibble helper width");
  end

  logic                  tick;
  logic [IW-1:0]         idx, idx_n;
  logic [W-1:0]          active, active_n, shadow, shadow_n;
  logic                  pending, pending_n, invalid, invalid_n;
  logic                  load_bad;
  logic [BCD_W-1:0]      abcd_q, nib_n;
  logic [NUM_DIGITS-1:0] en_q, en_n;
  logic                  blank_q, blank_n;

  disp_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // State register; display outputs are registered from next-state decode so
  // they change on the very edge the index (or frame) changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      active  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
      invalid <= 1'b0;
      abcd_q  <= '0;
      en_q    <= NUM_DIGITS'(1);
      blank_q <= 1'b0;
    end else begin
      idx     <= idx_n;
      active  <= active_n;
      shadow  <= shadow_n;
      pending <= pending_n;
      invalid <= invalid_n;
      abcd_q  <= nib_n;
      en_q    <= en_n;
      blank_q <= blank_n;
    end
  end

  always_comb begin
    load_bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (get_nibble(NIB_SRC_W'(bus.digits_in), i) > MAX_NIB) load_bad = 1'b1;
    end
  end

  // Next state: a load taken on the swap edge still lands in the shadow
  // and keeps pending set, because it is evaluated after the swap.
  always_comb begin
    idx_n     = idx;
    active_n  = active;
    shadow_n  = shadow;
    pending_n = pending;
    invalid_n = invalid;
    if (tick) begin
      idx_n = (idx == LAST_IDX) ? '0 : idx + IW'(1);
      if ((idx == LAST_IDX) && pending) begin
        active_n  = shadow;
        pending_n = 1'b0;
      end
    end
    if (bus.load) begin
      shadow_n  = bus.digits_in;
      pending_n = 1'b1;
      if (load_bad) invalid_n = 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] zero_from;

  // zero_from[i]: digit i and every more-significant digit are zero.
  always_comb begin
    zero_from = '0;
    zero_from[NUM_DIGITS-1] = (get_nibble(NIB_SRC_W'(active_n), NUM_DIGITS - 1) == '0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (get_nibble(NIB_SRC_W'(active_n), i) == '0);
    end
  end
`endif

  always_comb begin
    nib_n   = get_nibble(NIB_SRC_W'(active_n), int'(idx_n));
    en_n    = NUM_DIGITS'(1) << idx_n;
    blank_n = (nib_n > MAX_NIB);
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_n != '0) && zero_from[idx_n]) blank_n = 1'b1;
`endif
  end

  assign bus.A        = abcd_q[3];
  assign bus.B        = abcd_q[2];
  assign bus.C        = abcd_q[1];
  assign bus.D        = abcd_q[0];
  assign bus.digit_en = en_q;
  assign bus.blank    = blank_q;
  assign bus.pending  = pending;
  assign bus.invalid  = invalid;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner: directed table, corner sequences, random vs. model.
module tb_bcd_display_scanner;

  localparam int N   = 4;
  localparam int DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_display_scanner_if #(.NUM_DIGITS(N)) bus ();

  bcd_display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: frame position from edge count, buffers as plain values.
  logic [15:0] m_active, m_shadow;
  bit          m_pend, m_inv;
  int          m_k;

  typedef struct {
    bit          ld;
    logic [15:0] din;
    int          w;
    logic [3:0]  en;
    logic [3:0]  abcd;
    bit          blank;
    bit          pend;
    bit          inv;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] dut_out();
    return {bus.digit_en, bus.A, bus.B, bus.C, bus.D, bus.blank, bus.pending, bus.invalid};
  endfunction

  function automatic logic [10:0] model_out();
    int          idx;
    logic [15:0] upper;
    logic [3:0]  nib;
    bit          bl;
    idx   = (m_k / DIV) % N;
    upper = m_active >> (4 * idx);
    nib   = upper[3:0];
    bl    = (nib > 4'd9) || (LZB && (idx != 0) && (upper == 16'd0));
    return {4'(1 << idx), nib, bl, m_pend, m_inv};
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_active = '0; m_shadow = '0; m_pend = 0; m_inv = 0; m_k = 0;
    end else begin
      m_k++;
      if ((m_k % (DIV * N) == 0) && m_pend) begin
        m_active = m_shadow;
        m_pend   = 0;
      end
      if (bus.load) begin
        m_shadow = bus.digits_in;
        m_pend   = 1;
        for (int i = 0; i < N; i++) begin
          if (((bus.digits_in >> (4 * i)) & 16'hF) > 16'd9) m_inv = 1;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model", 16'(dut_out()), 16'(model_out()));
  endtask

  task automatic step(input bit ld, input logic [15:0] d, input int w);
    bus.load      = ld;
    bus.digits_in = d;
    cycle();
    bus.load = 1'b0;
    repeat (w) cycle();
  endtask

  task automatic expect_out(input string name, input logic [3:0] en, input logic [3:0] abcd,
                            input bit bl, input bit pend, input bit inv);
    check(name, 16'(dut_out()), 16'({en, abcd, bl, pend, inv}));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.load = 1'b0;
    repeat (n) cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.load      = 1'b0;
    bus.digits_in = '0;
    m_active = '0; m_shadow = '0; m_pend = 0; m_inv = 0; m_k = 0;

    //          ld  din      w   en       abcd  bl pend inv
    tbl[0]  = '{1, 16'h1234, 0,  4'b0001, 4'h0, 0, 1, 0};
    tbl[1]  = '{0, 16'h1234, 14, 4'b0001, 4'h4, 0, 0, 0};
    tbl[2]  = '{0, 16'h1234, 3,  4'b0010, 4'h3, 0, 0, 0};
    tbl[3]  = '{0, 16'h1234, 3,  4'b0100, 4'h2, 0, 0, 0};
    tbl[4]  = '{1, 16'h5678, 0,  4'b0100, 4'h2, 0, 1, 0};
    tbl[5]  = '{0, 16'h5678, 6,  4'b0001, 4'h8, 0, 0, 0};
    tbl[6]  = '{1, 16'h1111, 0,  4'b0001, 4'h8, 0, 1, 0};
    tbl[7]  = '{0, 16'h1111, 13, 4'b1000, 4'h5, 0, 1, 0};
    tbl[8]  = '{1, 16'h2222, 0,  4'b0001, 4'h1, 0, 1, 0};
    tbl[9]  = '{0, 16'h2222, 15, 4'b0001, 4'h2, 0, 0, 0};
    tbl[10] = '{1, 16'h12A4, 0,  4'b0001, 4'h2, 0, 1, 1};
    tbl[11] = '{0, 16'h12A4, 14, 4'b0001, 4'h4, 0, 0, 1};
    tbl[12] = '{0, 16'h12A4, 3,  4'b0010, 4'hA, 1, 0, 1};
    tbl[13] = '{0, 16'h12A4, 3,  4'b0100, 4'h2, 0, 0, 1};

    do_reset(3);
    expect_out("reset", 4'b0001, 4'h0, 0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].ld, tbl[i].din, tbl[i].w);
      expect_out($sformatf("vec%0d", i), tbl[i].en, tbl[i].abcd, tbl[i].blank,
                 tbl[i].pend, tbl[i].inv);
    end

    do_reset(2);
    expect_out("rst_clears_invalid", 4'b0001, 4'h0, 0, 0, 0);

    // Leading-zero handling of 0050 and 0000.
    step(1, 16'h0050, 15);
    expect_out("lz_d0", 4'b0001, 4'h0, 0, 0, 0);
    step(0, 16'h0050, 3);
    expect_out("lz_d1", 4'b0010, 4'h5, 0, 0, 0);
    step(0, 16'h0050, 3);
    expect_out("lz_d2", 4'b0100, 4'h0, LZB, 0, 0);
    step(0, 16'h0050, 3);
    expect_out("lz_d3", 4'b1000, 4'h0, LZB, 0, 0);
    step(1, 16'h0000, 3);
    expect_out("zero_d0", 4'b0001, 4'h0, 0, 0, 0);
    step(0, 16'h0000, 3);
    expect_out("zero_d1", 4'b0010, 4'h0, LZB, 0, 0);
    step(0, 16'h0000, 3);
    expect_out("zero_d2", 4'b0100, 4'h0, LZB, 0, 0);

    // Random loads, odd digits and occasional mid-run resets against the model.
    do_reset(1);
    for (int c = 0; c < 800; c++) begin
      logic [15:0] d;
      for (int j = 0; j < N; j++) begin
        logic [3:0] nb;
        case ($urandom_range(0, 5))
          0, 1:    nb = 4'd0;
          2:       nb = 4'($urandom_range(0, 15));
          default: nb = 4'($urandom_range(0, 9));
        endcase
        d[4*j +: 4] = nb;
      end
      rst           = ($urandom_range(0, 199) == 0);
      bus.load      = ($urandom_range(0, 11) == 0);
      bus.digits_in = d;
      cycle();
    end
    rst      = 1'b0;
    bus.load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
Time-multiplexed driver for a multi-digit common-anode/cathode 7-segment display built from one 7448-style BCD-to-7-segment decoder. It holds NUM_DIGITS packed BCD digits and presents one digit at a time on A,B,C,D (A = MSB), which feed the decoder inputs directly. It also drives the matching one-hot digit enable and a blank line for the decoder's blanking input. Loads are double-buffered and swapped only at frame boundaries, so the display never tears.

Parameters:
NUM_DIGITS, 4, number of display digits; legal range >= 2.
REFRESH_DIV, 1000, clk cycles each digit is shown; legal range >= 1.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
load  input  1  single-cycle strobe; captures digits_in into the shadow register.
digits_in  input  4*NUM_DIGITS  packed BCD; nibble i = digits_in[4i+3:4i]; digit 0 is least significant/rightmost.
A  output  1  bit 3 (MSB) of the current BCD digit.
B  output  1  bit 2.
C  output  1  bit 1.
D  output  1  bit 0 (LSB).
digit_en  output  NUM_DIGITS  one-hot, active-high enable of the digit currently shown.
blank  output  1  1 = decoder must blank the current digit (drives BI).
pending  output  1  1 = shadow holds data not yet shown.
invalid  output  1  sticky; set when a load contains any nibble > 9.

Behaviour:
- All outputs are registered. No combinational path exists from inputs to outputs.
- Reset (rst = 1 at an edge, takes priority over everything, including mid-frame and mid-load):
  - active and shadow registers = 0; pending = 0; invalid = 0.
  - prescaler = 0; index = 0; digit_en = 1 (digit 0).
  - A..D = 0; blank = 0.
- Prescaler: counts 0..REFRESH_DIV-1.
  - At count REFRESH_DIV-1 it wraps to 0 and index advances: index+1, or NUM_DIGITS-1 -> 0.
  - A..D, digit_en and blank are updated on that same edge from the new index, so every digit is shown exactly REFRESH_DIV cycles.
  - REFRESH_DIV = 1 advances every cycle.
- Frame swap: on the edge where index wraps to 0 with pending = 1:
  - active <= shadow; pending <= 0.
  - Digit 0 outputs on that edge come from the new (shadow) value.
- Load:
  - load = 1 sets shadow <= digits_in and pending <= 1.
  - A load while pending = 1 overwrites the shadow (last load wins).
  - Load and swap on the same edge: the swap uses the old shadow, the new data enters the shadow, and pending stays 1.
- Invalid digits:
  - invalid is set on an accepted load with any nibble > 9 and clears only on rst.
  - Any displayed nibble > 9 forces blank = 1; A..D still carry the raw value.
- Digit enables: digit_en is always exactly one-hot; no all-zero or multi-hot state is reachable.
- State machine: none beyond the index ring (states DIGIT_0..DIGIT_N-1, advancing on prescaler wrap).

Optional Feature:
Macro: LEADING_ZERO_BLANK_EN.
- Defined: digit i (i != 0) shows blank = 1 when it and every more-significant digit of active are 0. Digit 0 is never blanked for zero, so value 0 shows a single "0".
- Not defined: blank depends only on the invalid-digit rule.

Decomposition:
- Shared package bcd_disp_pkg holds:
  - localparam BCD_W = 4 and BCD_MAX = 9.
  - A function for the nibble extract by index.
  - The clog2-based index width helper.
- One natural sub-module: disp_prescaler (parameter DIV; ports clk, rst, tick), a cycle counter emitting a 1-cycle tick at wrap.
- Index ring, buffers and blank logic stay in bcd_display_scanner.

Test Plan:
- Reset: hold rst 3 cycles → digit_en = 4'b0001, {A,B,C,D} = 0, blank = 0, pending = 0, invalid = 0 the edge after rst falls.
- Scan (REFRESH_DIV = 4): load 16'h1234, then wait for frame wrap → digit_en runs 0001/0010/0100/1000 for 4 cycles each, with ABCD = 4, 3, 2, 1 respectively; then repeats.
- Double buffer: load 16'h5678 mid-frame → pending = 1, current frame still shows 1234; the next wrap shows 8 on digit 0 and pending = 0.
- Same-edge load and swap: pending = 1 with shadow 16'h1111, load 16'h2222 on the wrap edge → frame shows 1111, pending stays 1, next frame shows 2222.
- Invalid: load 16'h12A4 → invalid = 1 next edge; digit 1 shows ABCD = 4'hA with blank = 1; rst clears invalid.
- LEADING_ZERO_BLANK_EN defined: load 16'h0050 → digits 3 and 2 blank = 1, digit 1 shows 5, digit 0 shows 0 with blank = 0. Load 16'h0000 → only digit 0 unblanked.
